// File: rtl/adder_pkg.sv
// Shared types and reference arithmetic for the fast_adder checker.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package adder_pkg;

    localparam int ADDER_W = 64;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDER_W-1:0] p;
        logic [ADDER_W-1:0] q;
        logic               cin;
        logic               operation;
    } operand_t;

    // Subtract treats cin as borrow-in, so carry out = 1 means no borrow.
    function automatic logic [ADDER_W:0] calc_expected(input operand_t op);
        logic [ADDER_W:0] a;
        logic [ADDER_W:0] b;
        logic [ADDER_W:0] c;
        a = {1'b0, op.p};
        if (op.operation == OP_ADD) begin
            b = {1'b0, op.q};
            c = {{ADDER_W{1'b0}}, op.cin};
        end else begin
            b = {1'b0, ~op.q};
            c = {{ADDER_W{1'b0}}, ~op.cin};
        end
        return a + b + c;
    endfunction

endpackage

// File: rtl/operand_delay_line.sv
// Delays operand sets to line up with the adder's output.
// Latency: LATENCY cycles from in_vld to out_vld.
// Backpressure: none; accepts one set per cycle, bubbles shift through.
module operand_delay_line
    import adder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_vld,
    input  operand_t in_dat,
    output logic     out_vld,
    output operand_t out_dat
);

    logic [LATENCY-1:0] vld_q;
    operand_t           dat_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only looked at when its valid bit is set.
    always_ff @(posedge clk) begin
        dat_q[0] <= in_dat;
        for (int i = 1; i < LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/adder_result_checker.sv
// Recomputes fast_adder results and flags mismatches, with counters and alarm.
// Latency: mismatch/counters update LATENCY+1 edges after operands are sampled.
// Backpressure: none; one check per cycle at full rate.
module adder_result_checker
    import adder_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int THRESHOLD = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [ADDER_W-1:0] p,
    input  logic [ADDER_W-1:0] q,
    input  logic               cin,
    input  logic               operation,
    input  logic [ADDER_W-1:0] result,
    input  logic               carry,
    input  logic               clr_alarm,
    output logic               mismatch,
    output logic               alarm,
    output logic [CNT_W-1:0]   checked_count,
    output logic [CNT_W-1:0]   err_count
);

    operand_t         in_dat;
    operand_t         dly_dat;
    logic             dly_vld;
    logic [ADDER_W:0] expected;
    state_t           state;
    state_t           state_nxt;
    logic [7:0]       tally;
    logic [7:0]       tally_nxt;
    logic [7:0]       tally_inc;
    logic             check_en;
    logic             do_check;
    logic             miss;

    assign in_dat = '{p: p, q: q, cin: cin, operation: operation};

    operand_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_valid),
        .in_dat  (in_dat),
        .out_vld (dly_vld),
        .out_dat (dly_dat)
    );

    assign expected  = calc_expected(dly_dat);
    assign do_check  = dly_vld & check_en;
    assign miss      = do_check & (expected != {carry, result});
    assign tally_inc = (tally == 8'hFF) ? tally : tally + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tally <= '0;
        end else begin
            state <= state_nxt;
            tally <= tally_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tally_nxt = tally;
        if (!enable) begin
            state_nxt = IDLE;
            tally_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARMED;
                    tally_nxt = '0;
                end
                ARMED: begin
                    if (miss) begin
                        tally_nxt = tally_inc;
                        if (tally_inc >= 8'(THRESHOLD)) begin
                            state_nxt = ALARM;
                        end
                    end
                end
                ALARM: begin
                    // A clear beats a coincident mismatch, which then seeds the new tally.
                    if (clr_alarm) begin
                        state_nxt = ARMED;
                        tally_nxt = {7'd0, miss};
                    end else if (miss) begin
                        tally_nxt = tally_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tally_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        check_en = enable && ((state == ARMED) || (state == ALARM));
        alarm    = (state == ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch      <= 1'b0;
            checked_count <= '0;
            err_count     <= '0;
        end else begin
            mismatch <= miss;
            if (do_check && (checked_count != '1)) begin
                checked_count <= checked_count + CNT_W'(1);
            end
            if (miss && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Concurrent error-detection monitor for the 64-bit `fast_adder` add/sub unit. It sits beside the adder, captures every operand set issued to it, recomputes the expected `{carry, result}` after the adder's pipeline latency, and compares it with the adder's actual output. It reports per-operation mismatches, keeps saturating check and error counters, and raises a sticky fault alarm for the security monitor when a threshold is reached.

## Interface
Parameters:
- `LATENCY`, 1: adder cycles from operand sample to valid `result`/`carry` (1..4).
- `THRESHOLD`, 1: mismatches needed to enter ALARM (1..255).
- `CNT_W`, 16: width of both counters.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  checking enabled; when 0, FSM is held in IDLE.
- `in_valid`  in  1  operand set issued to the adder this cycle.
- `p`  in  64  adder operand p.
- `q`  in  64  adder operand q.
- `cin`  in  1  adder carry/borrow input.
- `operation`  in  1  1 = add, 0 = subtract.
- `result`  in  64  adder sum/difference output.
- `carry`  in  1  adder carry output.
- `clr_alarm`  in  1  one-cycle pulse; returns ALARM to ARMED.
- `mismatch`  out  1  one-cycle pulse per failed comparison.
- `alarm`  out  1  high while in ALARM.
- `checked_count`  out  CNT_W  comparisons performed, saturating.
- `err_count`  out  CNT_W  mismatches detected, saturating.

## Operation
- Arithmetic reference (65-bit):
  - Add: `{carry, result} = p + q + cin`.
  - Subtract: `{carry, result} = p + ~q + !cin`. `cin` is borrow-in; `carry` = 1 means no borrow.
- Operand pipeline:
  - Shift register of depth LATENCY holding `{in_valid, p, q, cin, operation}`.
  - `in_valid` = 0 pushes a bubble.
- Comparison: when the delayed valid is high and the FSM is ARMED or ALARM, compare the recomputed 65-bit value against `{carry, result}` sampled in that same cycle.
- FSM states:
  - IDLE: no checking.
  - ARMED: checking active.
  - ALARM: checking continues; `alarm` is held high.
- FSM transitions:
  - IDLE→ARMED when `enable` = 1.
  - ARMED→ALARM when the mismatch count since the last arm/clear reaches THRESHOLD.
  - ALARM→ARMED on `clr_alarm`, which also zeroes the threshold tally.
  - Any state→IDLE when `enable` = 0.
  - The threshold tally is internal. It is 8 bits wide and is cleared on entering ARMED.
- Counters:
  - `checked_count` increments on every comparison.
  - `err_count` increments on every mismatch.
  - Both saturate at all-ones and are cleared only by `rst`. `enable` = 0 freezes them.
- Simultaneous events:
  - `clr_alarm` in the same cycle as a new mismatch: clear wins. The FSM goes to ARMED and the tally becomes 1. The mismatch is still counted in `err_count` and still pulses `mismatch`.
  - `clr_alarm` outside ALARM is ignored.

## Timing
- Operands are sampled at edge N while `in_valid` = 1. The adder output is checked at edge N+LATENCY.
- `mismatch` is registered: it is high for the cycle after edge N+LATENCY.
- The counters update at the same edge as `mismatch` rises.
- `alarm` rises at the same edge as the `mismatch` that reaches THRESHOLD.
- Back-to-back `in_valid` is supported at full rate, one check per cycle.
- Reset values: `mismatch` = 0, `alarm` = 0, `checked_count` = 0, `err_count` = 0, FSM = IDLE, and all pipeline valid bits = 0.
- Reset mid-operation: in-flight operand sets are discarded and never compared.
- Enabling: after `enable` rises, the FSM is ARMED from the next cycle. Operand sets already in the pipeline are compared if their check edge falls after ARMED is reached.

## Structure
- Shared package `adder_pkg`:
  - `ADDER_W` = 64.
  - FSM state enum {IDLE, ARMED, ALARM}.
  - Operation encodings `OP_ADD` = 1, `OP_SUB` = 0.
- Sub-module `operand_delay_line`: LATENCY-deep pipeline of valid plus payload, with synchronous reset of the valid bits only.
- Expected-value computation, compare, counters and FSM live in the top module.

## Test plan
- Add check: LATENCY = 1, `p` = 0x1111, `q` = 0x0101, `cin` = 0, op = 1, correct adder → expected 0x1212 / carry 0; `mismatch` stays 0; `checked_count` = 1.
- Subtract check: same `p`/`q`, `cin` = 0, op = 0 → expected 0x1010 / carry 1; no mismatch. Then `p` = 0, `q` = 1, op = 0 → 0xFFFF_FFFF_FFFF_FFFF / carry 0.
- Overflow: `p` = 0xFFFF_FFFF_FFFF_FFFF, `q` = 1, `cin` = 0, add → expected 0 / carry 1; no mismatch.
- Fault injection: force `result` bit 0 flipped on one op with THRESHOLD = 2 → one `mismatch` pulse, `err_count` = 1, `alarm` = 0. A second fault → `alarm` = 1. `clr_alarm` → `alarm` = 0 the next cycle and `err_count` stays 2.
- Reset mid-flight: LATENCY = 3, issue 3 back-to-back ops, assert `rst` one cycle later → no `mismatch` pulse and both counters = 0.
- Enable gating: `enable` = 0 during a faulty op → no pulse and counters unchanged. Re-enable and repeat the faulty op → pulse and `err_count` = 1.
